// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with
// handshake timeouts, a sticky trap state and a retired-instruction counter.
module cpu_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  output logic        o_instr_req,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_rdata,
  output logic [31:0] o_ir,
  input  logic        i_dec_reg_write,
  input  logic        i_dec_dmem_read,
  input  logic        i_dec_dmem_write,
  input  logic        i_dec_pcsel,
  input  logic        i_dec_illegal,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_rf_we,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [31:0] o_instret
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_wait;
  logic [1:0]  r_cause, w_cause;
  logic [31:0] r_ir, r_instret;
  logic        w_mem, w_bad, w_enter, w_stall;
  assign w_mem   = i_dec_dmem_read | i_dec_dmem_write;
  assign w_bad   = i_dec_illegal | (i_dec_dmem_read & i_dec_dmem_write);
  assign w_enter = (w_next != r_state) && (w_next == FETCH || w_next == MEM);
  assign w_stall = (o_instr_req & ~i_instr_ack) | (o_dmem_req & ~i_dmem_ack);
  assign o_ir         = r_ir;
  assign o_instret    = r_instret;
  assign o_trap_cause = r_cause;
  always_comb begin
    w_next      = r_state;
    w_cause     = r_cause;
    o_instr_req = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 1'b0;
    o_rf_we     = 1'b0;
    o_trap      = 1'b0;
    case (r_state)
      IDLE:   w_next = i_run ? FETCH : IDLE;
      FETCH: begin
        o_instr_req = 1'b1;
        // an ack in the same cycle the counter hits TIMEOUT still completes
        if (i_instr_ack) w_next = DECODE;
        else if (r_wait == TIMEOUT) begin
          w_next  = TRAP;
          w_cause = 2'b10;
        end
      end
      DECODE: begin
        w_next  = w_bad ? TRAP : EXEC;
        w_cause = w_bad ? 2'b01 : r_cause;
      end
      EXEC:   w_next = w_mem ? MEM : WB;
      MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_dec_dmem_write;
        if (i_dmem_ack) w_next = WB;
        else if (r_wait == TIMEOUT) begin
          w_next  = TRAP;
          w_cause = 2'b11;
        end
      end
      WB: begin
        o_pc_we  = 1'b1;
        o_pc_sel = i_dec_pcsel;
        o_rf_we  = i_dec_reg_write;
        w_next   = i_run ? FETCH : IDLE;
      end
      default: o_trap = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cause   <= 2'b00;
      r_wait    <= 8'd0;
      r_ir      <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      r_wait  <= w_enter ? 8'd0 : (w_stall ? r_wait + 8'd1 : r_wait);
      if (o_instr_req && i_instr_ack) r_ir <= i_instr_rdata;
      if (o_pc_we) r_instret <= r_instret + 32'd1;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream checked against a
// per-instruction cycle-trace model, plus timeout, trap, wrap and reset cases.
module tb_cpu_sequencer;
  localparam logic [7:0] TO = 8'd4;
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_FETCH = 7'b1000000;
  localparam logic [6:0] S_TRAP  = 7'b0000001;
  logic        clk, rst_n, run, iack, dack;
  logic [31:0] rdata, ir, instret, exp_instret;
  logic        ireq, dreq, dwe, pc_we, pc_sel, rf_we, trap;
  logic [1:0]  cause;
  logic [6:0]  outs;
  int          n_chk, n_err;
  cpu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run),
    .o_instr_req(ireq), .i_instr_ack(iack), .i_instr_rdata(rdata), .o_ir(ir),
    .i_dec_reg_write(ir[0]), .i_dec_dmem_read(ir[1]), .i_dec_dmem_write(ir[2]),
    .i_dec_pcsel(ir[3]), .i_dec_illegal(ir[4]),
    .o_dmem_req(dreq), .o_dmem_we(dwe), .i_dmem_ack(dack),
    .o_pc_we(pc_we), .o_pc_sel(pc_sel), .o_rf_we(rf_we),
    .o_trap(trap), .o_trap_cause(cause), .o_instret(instret)
  );
  assign outs = {ireq, dreq, dwe, pc_we, pc_sel, rf_we, trap};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_check(input string tag);
    chk({tag, "_outs"}, 32'(outs), 32'(S_NONE));
    chk({tag, "_ir"}, ir, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    chk({tag, "_cause"}, 32'(cause), 32'd0);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    #1 reset_check("rst");
    next;
    chk("rst_hold", 32'(outs), 32'(S_NONE));
    rst_n = 1'b1;
    exp_instret = 32'd0;
  endtask
  task automatic idle_to_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      #1 chk("idle", 32'(outs), 32'(S_NONE));
      next;
    end
    run = 1'b1;
    #1 chk("idle_go", 32'(outs), 32'(S_NONE));
    next;
  endtask
  // One instruction from FETCH entry: fw/mw are the extra wait cycles before each ack.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit go);
    bit rw, wr, ps, mem;
    rw = ins[0]; wr = ins[2]; ps = ins[3]; mem = ins[1] | ins[2];
    for (int c = 0; c <= fw; c++) begin
      iack  = (c == fw);
      rdata = (c == fw) ? ins : $urandom;
      #1 chk("fetch", 32'(outs), 32'(S_FETCH));
      next;
    end
    iack = 1'b0;
    #1 chk("decode", 32'(outs), 32'(S_NONE));
    chk("ir", ir, ins);
    next;
    #1 chk("exec", 32'(outs), 32'(S_NONE));
    next;
    if (mem)
      for (int c = 0; c <= mw; c++) begin
        dack = (c == mw);
        #1 chk("mem", 32'(outs), 32'({2'b01, wr, 4'b0000}));
        next;
      end
    dack = 1'b0;
    run  = go;
    #1 chk("wb", 32'(outs), 32'({3'b000, 1'b1, ps, rw, 1'b0}));
    next;
    exp_instret = exp_instret + 32'd1;
    chk("instret", instret, exp_instret);
  endtask
  task automatic trap_hold(input logic [1:0] exp_cause);
    for (int i = 0; i < 4; i++) begin
      run  = 1'b1;
      iack = 1'($urandom);
      dack = 1'($urandom);
      #1 chk("trap", 32'(outs), 32'(S_TRAP));
      chk("trap_cause", 32'(cause), 32'(exp_cause));
      next;
    end
    iack = 1'b0;
    dack = 1'b0;
  endtask
  task automatic fetch_decode(input logic [31:0] ins);
    iack  = 1'b1;
    rdata = ins;
    #1 chk("fetch", 32'(outs), 32'(S_FETCH));
    next;
    iack = 1'b0;
    #1 chk("decode", 32'(outs), 32'(S_NONE));
    next;
  endtask
  initial begin
    logic [31:0] ins;
    bit go;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; run = 1'b0; iack = 1'b0; dack = 1'b0; rdata = 32'd0;
    exp_instret = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset_check("por");
    rst_n = 1'b1;
    idle_to_fetch(2);
    run_instr(32'h1, 0, 0, 1);
    run_instr(32'h3, 0, 3, 1);
    run_instr(32'h8, 0, 0, 1);
    run_instr(32'h4, 1, 2, 1);
    run_instr(32'h1, 4, 4, 0);
    idle_to_fetch(1);
    for (int k = 0; k < 40; k++) begin
      ins = $urandom;
      ins[4] = 1'b0;
      if (ins[1] && ins[2]) ins[2] = 1'b0;
      go = ($urandom_range(0, 3) != 0);
      run_instr(ins, $urandom_range(0, 4), $urandom_range(0, 4), go);
      if (!go) idle_to_fetch($urandom_range(0, 3));
    end
    run_instr(32'h1, 0, 0, 0);
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    chk("preload", instret, exp_instret);
    idle_to_fetch(0);
    run_instr(32'h1, 0, 0, 0);
    chk("wrap", instret, 32'd0);
    idle_to_fetch(0);
    fetch_decode(32'h3);
    #1 chk("exec", 32'(outs), 32'(S_NONE));
    next;
    #1 chk("mem_pre", 32'(outs), 32'(7'b0100000));
    #1 rst_n = 1'b0;
    #1 reset_check("mid_mem");
    next;
    chk("mid_mem_hold", 32'(outs), 32'(S_NONE));
    rst_n = 1'b1;
    exp_instret = 32'd0;
    idle_to_fetch(0);
    #1 chk("fetch_pre", 32'(outs), 32'(S_FETCH));
    #1 rst_n = 1'b0;
    #1 reset_check("mid_fetch");
    next;
    rst_n = 1'b1;
    idle_to_fetch(0);
    fetch_decode(32'h7);
    trap_hold(2'b01);
    do_reset;
    idle_to_fetch(0);
    for (int c = 0; c <= int'(TO); c++) begin
      iack = 1'b0;
      #1 chk("fetch_to", 32'(outs), 32'(S_FETCH));
      next;
    end
    trap_hold(2'b10);
    do_reset;
    idle_to_fetch(0);
    fetch_decode(32'h4);
    #1 chk("exec", 32'(outs), 32'(S_NONE));
    next;
    for (int c = 0; c <= int'(TO); c++) begin
      dack = 1'b0;
      #1 chk("mem_to", 32'(outs), 32'(7'b0110000));
      next;
    end
    trap_hold(2'b11);
    do_reset;
    idle_to_fetch(0);
    run_instr(32'h9, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
